bus_arbiter: RTL and testbench

- Arbitrates the shared bit-serial system bus among NUM_MASTERS masters.
- Routes the granted master to one of NUM_SLAVES slave input ports.
- Grants only when the addressed slave reports ready, i.e. the slave port's address and data capture machines are both idle.
- Holds the grant until the master signals completion, or a timeout expires, then inserts a one-cycle bus gap.

---
 rtl/bus_arb_pkg.sv | 19 +
 rtl/arb_priority_picker.sv | 33 +++
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bit-serial system bus arbiter.
package bus_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Width of the master_sel bus-mux index
  localparam int MSEL_W = 2;

  // Timeout counter width: enough bits to hold TIMEOUT itself
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/arb_priority_picker.sv
// Combinational circular priority picker: first eligible master at or after
// the start index wins, wrapping around the NUM_MASTERS range.
module arb_priority_picker
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] eligible,
  input  logic [MSEL_W-1:0]      start,
  output logic [MSEL_W-1:0]      winner,
  output logic                   valid
);

  int idx;

  // Scan offsets from the start pointer; the first eligible hit is kept
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NUM_MASTERS; off++) begin
      idx = int'(start) + off;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!valid && eligible[j] && (j == idx)) begin
          valid  = 1'b1;
          winner = MSEL_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared bit-serial bus arbiter: grants one master at a time to a ready
// slave port, holds the grant until done/request drop/timeout, then leaves
// a one-cycle gap. Define BUS_ARB_ROUND_ROBIN_EN for rotating priority;
// otherwise lowest master index always wins.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SID_W       = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_MASTERS-1:0]       m_req,
  input  logic [NUM_MASTERS*SID_W-1:0] m_slave_id,
  input  logic [NUM_MASTERS-1:0]       m_done,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [NUM_MASTERS-1:0]       m_grant,
  output logic [MSEL_W-1:0]            master_sel,
  output logic [NUM_SLAVES-1:0]        slave_sel,
  output logic                         bus_busy,
  output logic                         timeout_err
);

  localparam int             CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t             state, next_state;
  logic [NUM_MASTERS-1:0] eligible;
  logic [SID_W-1:0]       id_v;
  logic [MSEL_W-1:0]      pick_winner;
  logic                   pick_valid;
  logic [SID_W-1:0]       pick_id;
  logic [MSEL_W-1:0]      winner_q;
  logic [SID_W-1:0]       id_q;
  logic [CNT_W-1:0]       cnt;
  logic [MSEL_W-1:0]      rr_ptr;
  logic                   req_w, done_w;
  logic                   grant_start, release_now, timeout_hit;

  // A master is eligible only if it requests an in-range, ready slave
  always_comb begin
    eligible = '0;
    id_v     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      id_v = m_slave_id[i*SID_W +: SID_W];
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if ((int'(id_v) == s) && s_ready[s]) eligible[i] = m_req[i];
      end
    end
  end

  arb_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .eligible(eligible),
    .start   (rr_ptr),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  // Select the winner's slave id and the current owner's req/done bits
  always_comb begin
    pick_id = '0;
    req_w   = 1'b0;
    done_w  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_winner == MSEL_W'(i)) pick_id = m_slave_id[i*SID_W +: SID_W];
      if (winner_q == MSEL_W'(i)) begin
        req_w  = m_req[i];
        done_w = m_done[i];
      end
    end
  end

  assign grant_start = (state == IDLE) && pick_valid;
  assign release_now = !req_w || done_w || (cnt == TO_LAST);
  assign timeout_hit = req_w && !done_w && (cnt == TO_LAST);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Rotate the search start to just past each new owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_start) begin
      rr_ptr <= (pick_winner == MSEL_W'(NUM_MASTERS - 1)) ? '0 : pick_winner + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // Latch owner and target slave when a grant is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner_q <= '0;
      id_q     <= '0;
    end else if (grant_start) begin
      winner_q <= pick_winner;
      id_q     <= pick_id;
    end
  end

  // Count BUSY cycles from the start of each grant, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (grant_start) begin
      cnt <= '0;
    end else if ((state == BUSY) && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_valid)  next_state = BUSY;
      BUSY:    if (release_now) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: grant/select decoded from the latched owner while BUSY
  always_comb begin
    m_grant     = '0;
    master_sel  = '0;
    slave_sel   = '0;
    bus_busy    = 1'b0;
    timeout_err = 1'b0;
    if (state == BUSY) begin
      for (int i = 0; i < NUM_MASTERS; i++) m_grant[i] = (winner_q == MSEL_W'(i));
      for (int s = 0; s < NUM_SLAVES; s++)  slave_sel[s] = (int'(id_q) == s);
      master_sel  = winner_q;
      bus_busy    = 1'b1;
      timeout_err = timeout_hit;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (2 masters, 3 slaves, TIMEOUT=8).
module tb_bus_arbiter;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int TO = 8;

  logic       clk;
  logic       reset;
  logic [1:0] m_req;
  logic [3:0] m_slave_id;
  logic [1:0] m_done;
  logic [2:0] s_ready;
  logic [1:0] m_grant;
  logic [1:0] master_sel;
  logic [2:0] slave_sel;
  logic       bus_busy;
  logic       timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: current owner (-1 none), its slave, cycles held, gap flag
  int own, own_id, held, ptr;
  bit gap;

  typedef struct {
    logic [1:0] req;
    logic [3:0] ids;
    logic [1:0] done;
    logic [2:0] ready;
    logic [1:0] exp_grant;
    logic [1:0] exp_msel;
    logic [2:0] exp_ssel;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[18];
  int   grant_log[$];

  bus_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SID_W(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_slave_id(m_slave_id),
    .m_done(m_done), .s_ready(s_ready), .m_grant(m_grant),
    .master_sel(master_sel), .slave_sel(slave_sel), .bus_busy(bus_busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bitOf(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) != 4'd0;
  endfunction

  function automatic int idOf(input int i);
    return int'((m_slave_id >> (i * SW)) & 4'h3);
  endfunction

  function automatic bit eligibleOf(input int i);
    int id;
    id = idOf(i);
    return bitOf({2'b00, m_req}, i) && (id < NS) && bitOf({1'b0, s_ready}, id);
  endfunction

  task automatic modelReset();
    own = -1; own_id = 0; held = 0; ptr = 0; gap = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelStep();
    int i;
    if (own >= 0) begin
      if (!bitOf({2'b00, m_req}, own) || bitOf({2'b00, m_done}, own) || held == TO - 1) begin
        own = -1; gap = 1'b1;
      end else begin
        held++;
      end
    end else if (gap) begin
      gap = 1'b0;
    end else begin
      for (int k = 0; k < NM; k++) begin
        i = (ptr + k) % NM;
        if (own < 0 && eligibleOf(i)) begin
          own = i; own_id = idOf(i); held = 0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          ptr = (i + 1) % NM;
`endif
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    int eg, ess, eb, et;
    eg  = (own >= 0) ? (1 << own) : 0;
    ess = (own >= 0) ? (1 << own_id) : 0;
    eb  = (own >= 0) ? 1 : 0;
    et  = (own >= 0 && bitOf({2'b00, m_req}, own) && !bitOf({2'b00, m_done}, own) && held == TO - 1) ? 1 : 0;
    checkOutput({tag, ".grant"},  int'(m_grant),     eg);
    checkOutput({tag, ".msel"},   int'(master_sel),  (own >= 0) ? own : 0);
    checkOutput({tag, ".ssel"},   int'(slave_sel),   ess);
    checkOutput({tag, ".busy"},   int'(bus_busy),    eb);
    checkOutput({tag, ".tmo"},    int'(timeout_err), et);
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [3:0] ids,
                               input logic [1:0] done, input logic [2:0] ready);
    @(negedge clk);
    m_req = req; m_slave_id = ids; m_done = done; s_ready = ready;
    #1;
  endtask

  task automatic cycle(input string tag, input logic [1:0] req, input logic [3:0] ids,
                       input logic [1:0] done, input logic [2:0] ready);
    applyStimulus(req, ids, done, ready);
    checkModel(tag);
    @(posedge clk);
    modelStep();
  endtask

  task automatic setVec(input int n, input logic [1:0] req, input logic [3:0] ids,
                        input logic [1:0] done, input logic [2:0] ready, input logic [1:0] eg,
                        input logic [1:0] ems, input logic [2:0] ess, input logic eb);
    vecs[n] = '{req, ids, done, ready, eg, ems, ess, eb};
  endtask

  initial begin
    int prev_grant;
    logic [1:0] dn;

    // Vectors: single request, out-of-range id, slave-not-ready with bypass
    setVec( 0, 2'b01, 4'b0010, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec( 1, 2'b01, 4'b0010, 2'b00, 3'b111, 2'b01, 2'd0, 3'b100, 1'b1);
    setVec( 2, 2'b01, 4'b0010, 2'b01, 3'b111, 2'b01, 2'd0, 3'b100, 1'b1);
    setVec( 3, 2'b00, 4'b0010, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec( 4, 2'b00, 4'b0010, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec( 5, 2'b01, 4'b0011, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec( 6, 2'b01, 4'b0011, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec( 7, 2'b01, 4'b0011, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec( 8, 2'b01, 4'b0001, 2'b00, 3'b101, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec( 9, 2'b01, 4'b0001, 2'b00, 3'b101, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec(10, 2'b11, 4'b0001, 2'b00, 3'b101, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec(11, 2'b11, 4'b0001, 2'b10, 3'b101, 2'b10, 2'd1, 3'b001, 1'b1);
    setVec(12, 2'b01, 4'b0001, 2'b00, 3'b101, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec(13, 2'b01, 4'b0001, 2'b00, 3'b101, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec(14, 2'b01, 4'b0001, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec(15, 2'b01, 4'b0001, 2'b01, 3'b111, 2'b01, 2'd0, 3'b010, 1'b1);
    setVec(16, 2'b00, 4'b0001, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);
    setVec(17, 2'b00, 4'b0001, 2'b00, 3'b111, 2'b00, 2'd0, 3'b000, 1'b0);

    reset = 1'b0; m_req = '0; m_slave_id = '0; m_done = '0; s_ready = '0;
    modelReset();
    #12;
    checkOutput("reset.grant", int'(m_grant), 0);
    checkOutput("reset.ssel",  int'(slave_sel), 0);
    checkOutput("reset.msel",  int'(master_sel), 0);
    checkOutput("reset.busy",  int'(bus_busy), 0);
    checkOutput("reset.tmo",   int'(timeout_err), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven directed vectors
    for (int n = 0; n < 18; n++) begin
      applyStimulus(vecs[n].req, vecs[n].ids, vecs[n].done, vecs[n].ready);
      checkOutput($sformatf("vec%0d.grant", n), int'(m_grant),   int'(vecs[n].exp_grant));
      checkOutput($sformatf("vec%0d.msel", n),  int'(master_sel), int'(vecs[n].exp_msel));
      checkOutput($sformatf("vec%0d.ssel", n),  int'(slave_sel),  int'(vecs[n].exp_ssel));
      checkOutput($sformatf("vec%0d.busy", n),  int'(bus_busy),   int'(vecs[n].exp_busy));
      checkModel($sformatf("vec%0d", n));
      @(posedge clk);
      modelStep();
    end

    // Contention: both request, each owner finishes on its 5th BUSY cycle
    prev_grant = 0;
    for (int c = 0; c < 24; c++) begin
      dn = (own >= 0 && held == 4) ? 2'(1 << own) : 2'b00;
      applyStimulus(2'b11, 4'b0100, dn, 3'b111);
      if (m_grant != 2'b00 && prev_grant == 0) grant_log.push_back(int'(m_grant));
      prev_grant = int'(m_grant);
      checkModel("contend");
      @(posedge clk);
      modelStep();
    end
    checkOutput("contend.count_ok", (grant_log.size() >= 3) ? 1 : 0, 1);
    if (grant_log.size() >= 3) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      checkOutput("contend.g0", grant_log[0], 1);
      checkOutput("contend.g1", grant_log[1], 2);
      checkOutput("contend.g2", grant_log[2], 1);
`else
      checkOutput("contend.g0", grant_log[0], 1);
      checkOutput("contend.g1", grant_log[1], 1);
      checkOutput("contend.g2", grant_log[2], 1);
`endif
    end
    for (int c = 0; c < 3; c++) cycle("drain", 2'b00, 4'b0000, 2'b00, 3'b111);

    // Timeout without done, then timeout cycle coinciding with done
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 11; c++) begin
        dn = (pass == 1 && c == 8) ? 2'b10 : 2'b00;
        applyStimulus((c <= 8) ? 2'b10 : 2'b00, 4'b0000, dn, 3'b111);
        checkOutput($sformatf("tmo%0d.c%0d.err", pass, c), int'(timeout_err),
                    (pass == 0 && c == 8) ? 1 : 0);
        checkOutput($sformatf("tmo%0d.c%0d.grant", pass, c), int'(m_grant),
                    (c >= 1 && c <= 8) ? 2 : 0);
        checkModel("tmo");
        @(posedge clk);
        modelStep();
      end
    end

    // Asynchronous reset while BUSY
    cycle("pre_rst", 2'b01, 4'b0001, 2'b00, 3'b111);
    cycle("pre_rst", 2'b11, 4'b0001, 2'b00, 3'b111);
    @(negedge clk);
    checkOutput("mid_rst.busy_before", int'(bus_busy), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst.grant", int'(m_grant), 0);
    checkOutput("mid_rst.ssel",  int'(slave_sel), 0);
    checkOutput("mid_rst.busy",  int'(bus_busy), 0);
    checkOutput("mid_rst.tmo",   int'(timeout_err), 0);
    m_req = '0; m_done = '0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    cycle("post_rst", 2'b11, 4'b0001, 2'b00, 3'b111);
    applyStimulus(2'b11, 4'b0001, 2'b01, 3'b111);
    checkOutput("post_rst.first_grant", int'(m_grant), 1);
    @(posedge clk);
    modelStep();

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      cycle("rand", 2'($urandom), 4'($urandom),
            ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00,
            ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
